ludh_inst_loader: RTL and testbench

LUDH_INST_LOADER -- requirements
Module: ludh_inst_loader

---
 rtl/ludh_pkg.sv | 20 ++
 rtl/ludh_inst_loader_if.sv | 9 +
 rtl/ludh_beat_packer.sv | 59 +++++
 rtl/ludh_inst_loader.sv | 130 +++++++++++++
 tb/tb_ludh_inst_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ludh_pkg.sv
// Shared types and sizing for the instruction loader: FSM state encoding,
// default widths and the beats-per-word derivation.
package ludh_pkg;

  localparam int unsigned DefaultAddrWidth = 12;
  localparam int unsigned DefaultCtrlWidth = 307;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } state_e;

  // Number of 32-bit beats needed to carry one instruction word.
  function automatic int unsigned calc_beats(input int unsigned ctrl_width);
    return (ctrl_width + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/ludh_inst_loader_if.sv
// Beat stream carrying 32-bit instruction parts into the loader.
interface ludh_inst_loader_if;
  logic [31:0] S_DATA;
  logic        S_VALID;
  logic        S_READY;

  modport master (output S_DATA, output S_VALID, input S_READY);
  modport slave  (input S_DATA, input S_VALID, output S_READY);
endinterface

// File: rtl/ludh_beat_packer.sv
// Beat counter and word assembly register; beat k lands in bits [32k+31:32k].
// Optional LUDH_LOADER_PAD_CHECK_EN flags nonzero discarded bits on the final beat.
module ludh_beat_packer
  import ludh_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = DefaultCtrlWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [31:0]           data_i,
  output logic                  last_beat_o,
  output logic                  pad_err_o,
  output logic [CTRL_WIDTH-1:0] word_o
);

  localparam int unsigned BEATS = calc_beats(CTRL_WIDTH);
  localparam int unsigned CntW  = $clog2(BEATS + 1);

  logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CTRL_WIDTH-1:0] word_q, word_d;

  assign last_beat_o = (beat_cnt_q == CntW'(BEATS - 1));
  assign word_o      = word_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      beat_cnt_d = '0;
    end else if (accept_i) begin
      beat_cnt_d = last_beat_o ? '0 : beat_cnt_q + 1'b1;
      // Bits beyond CTRL_WIDTH-1 in the final beat simply have no destination.
      for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
        if (beat_cnt_q == CntW'(i / 32)) word_d[i] = data_i[i % 32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      word_q     <= word_d;
    end
  end

`ifdef LUDH_LOADER_PAD_CHECK_EN
  localparam int unsigned PadBits = BEATS * 32 - CTRL_WIDTH;
  localparam logic [31:0] PadMask = ~(32'hFFFF_FFFF >> PadBits);
  assign pad_err_o = accept_i && last_beat_o && |(data_i & PadMask);
`else
  assign pad_err_o = 1'b0;
`endif

endmodule

// File: rtl/ludh_inst_loader.sv
// Streams 32-bit beats into wide instruction words and writes them to BRAM.
// Pad-bit checking is enabled by defining LUDH_LOADER_PAD_CHECK_EN.
module ludh_inst_loader
  import ludh_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned CTRL_WIDTH = DefaultCtrlWidth
) (
  input  logic                  CLK_100,
  input  logic                  RST_N,
  input  logic                  LOAD_START,
  input  logic [ADDR_WIDTH-1:0] LOAD_BASE,
  input  logic [ADDR_WIDTH:0]   LOAD_COUNT,
  input  logic                  LOAD_ABORT,
  ludh_inst_loader_if.slave     beat,
  output logic [ADDR_WIDTH-1:0] INST_addr,
  output logic [CTRL_WIDTH-1:0] INST_din,
  output logic                  INST_en,
  output logic                  INST_we,
  output logic                  LOAD_BUSY,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR,
  output logic [ADDR_WIDTH:0]   WORDS_WRITTEN
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d, words_inc;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  s_ready, accept, clear, last_beat, pad_err;

  assign s_ready   = (state_q == StCollect);
  assign accept    = beat.S_VALID && s_ready;
  assign words_inc = words_q + 1'b1;

  ludh_beat_packer #(
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_packer (
    .clk_i       (CLK_100),
    .rst_ni      (RST_N),
    .clear_i     (clear),
    .accept_i    (accept),
    .data_i      (beat.S_DATA),
    .last_beat_o (last_beat),
    .pad_err_o   (pad_err),
    .word_o      (INST_din)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    clear   = 1'b0;
    case (state_q)
      StIdle: begin
        // Abort beats a coincident start.
        if (LOAD_START && !LOAD_ABORT) begin
          addr_d  = LOAD_BASE;
          count_d = LOAD_COUNT;
          words_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          clear   = 1'b1;
          state_d = (LOAD_COUNT == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (LOAD_ABORT) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else if (accept && last_beat) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The write itself always completes, even when aborted this cycle.
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        if (LOAD_ABORT) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else if (words_inc == count_q) begin
          state_d = StDone;
        end else begin
          state_d = StCollect;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (LOAD_START && (state_q != StIdle)) err_d = 1'b1;
    if (pad_err) err_d = 1'b1;
  end

  always_ff @(posedge CLK_100 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      addr_q  <= '0;
      words_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign beat.S_READY  = s_ready;
  assign INST_addr     = addr_q;
  assign INST_en       = (state_q == StWrite);
  assign INST_we       = (state_q == StWrite);
  assign LOAD_BUSY     = (state_q != StIdle);
  assign LOAD_DONE     = done_q;
  assign LOAD_ERR      = err_q;
  assign WORDS_WRITTEN = words_q;

endmodule

// File: tb/tb_ludh_inst_loader.sv
// Directed bench for ludh_inst_loader with hand-computed expectations.
module tb_ludh_inst_loader;
  localparam int AW = 12;
  localparam int CW = 307;
`ifdef LUDH_LOADER_PAD_CHECK_EN
  localparam logic PadExp = 1'b1;
`else
  localparam logic PadExp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, load_start, load_abort;
  logic [AW-1:0] load_base, inst_addr;
  logic [AW:0]   load_count, words_written;
  logic [CW-1:0] inst_din;
  logic          inst_en, inst_we, load_busy, load_done, load_err;

  always #5 clk = ~clk;

  ludh_inst_loader_if bif ();

  ludh_inst_loader #(
    .ADDR_WIDTH (AW),
    .CTRL_WIDTH (CW)
  ) dut (
    .CLK_100       (clk),
    .RST_N         (rst_n),
    .LOAD_START    (load_start),
    .LOAD_BASE     (load_base),
    .LOAD_COUNT    (load_count),
    .LOAD_ABORT    (load_abort),
    .beat          (bif),
    .INST_addr     (inst_addr),
    .INST_din      (inst_din),
    .INST_en       (inst_en),
    .INST_we       (inst_we),
    .LOAD_BUSY     (load_busy),
    .LOAD_DONE     (load_done),
    .LOAD_ERR      (load_err),
    .WORDS_WRITTEN (words_written)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int wr_n   = 0;
  logic [AW-1:0] wr_addr[64];
  logic [31:0]   wr_lo[64];
  logic [18:0]   wr_hi[64];
  logic          wr_rdy[64];
  logic          wr_en[64];
  int            wr_cyc[64];
  logic [31:0]   beat_data[40];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (inst_we) begin
      wr_addr[wr_n % 64] <= inst_addr;
      wr_lo[wr_n % 64]   <= inst_din[31:0];
      wr_hi[wr_n % 64]   <= inst_din[CW-1:288];
      wr_rdy[wr_n % 64]  <= bif.S_READY;
      wr_en[wr_n % 64]   <= inst_en;
      wr_cyc[wr_n % 64]  <= cyc;
      wr_n <= wr_n + 1;
    end
  end

  task automatic start(input logic [AW-1:0] base, input logic [AW:0] cnt);
    @(negedge clk);
    load_base  = base;
    load_count = cnt;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic stream(input int off, input int n, input int period);
    int k = 0;
    int t = 0;
    while (k < n && t < 1000) begin
      @(negedge clk);
      bif.S_VALID = ((t % period) == 0);
      bif.S_DATA  = beat_data[off+k];
      if (bif.S_VALID && bif.S_READY) k++;
      t++;
    end
    @(negedge clk);
    bif.S_VALID = 1'b0;
    checks++; if (k != n) $display("FAIL stream: accepted %0d beats, want %0d", k, n); else passed++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (load_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (load_busy !== 1'b0) $display("FAIL idle_timeout: busy still %b", load_busy); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; load_start = 1'b0; load_abort = 1'b0; load_base = '0; load_count = '0;
    bif.S_VALID = 1'b0; bif.S_DATA = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (load_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", load_busy); else passed++;
    checks++; if (load_done !== 1'b0) $display("FAIL rst_done: got %b want 0", load_done); else passed++;
    checks++; if (load_err !== 1'b0) $display("FAIL rst_err: got %b want 0", load_err); else passed++;
    checks++; if (words_written !== '0) $display("FAIL rst_words: got %0d want 0", words_written); else passed++;
    checks++; if (bif.S_READY !== 1'b0) $display("FAIL rst_ready: got %b want 0", bif.S_READY); else passed++;
    checks++; if ({inst_en, inst_we} !== 2'b00) $display("FAIL rst_en_we: got %b want 00", {inst_en, inst_we}); else passed++;
    checks++; if (inst_addr !== '0) $display("FAIL rst_addr: got %h want 0", inst_addr); else passed++;
    checks++; if (inst_din !== '0) $display("FAIL rst_din: got %h want 0", inst_din[31:0]); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_count();
    int b = wr_n;
    start(12'h123, 13'd0);
    checks++; if (load_busy !== 1'b1) $display("FAIL zero_busy: got %b want 1", load_busy); else passed++;
    checks++; if (load_done !== 1'b0) $display("FAIL zero_done_early: got %b want 0", load_done); else passed++;
    @(negedge clk);
    checks++; if (load_done !== 1'b1) $display("FAIL zero_done: got %b want 1", load_done); else passed++;
    checks++; if (load_busy !== 1'b0) $display("FAIL zero_idle: got %b want 0", load_busy); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (wr_n - b != 0) $display("FAIL zero_writes: got %0d want 0", wr_n - b); else passed++;
  endtask

  task automatic test_two_words();
    int b = wr_n;
    for (int i = 0; i < 40; i++) beat_data[i] = 32'(i);
    start(12'h010, 13'd2);
    checks++; if (load_done !== 1'b0) $display("FAIL tw_done_cleared: got %b want 0", load_done); else passed++;
    checks++; if (bif.S_READY !== 1'b1) $display("FAIL tw_ready: got %b want 1", bif.S_READY); else passed++;
    stream(0, 20, 1);
    wait_idle();
    checks++; if (wr_n - b != 2) $display("FAIL tw_writes: got %0d want 2", wr_n - b); else passed++;
    checks++; if (wr_addr[b%64] !== 12'h010) $display("FAIL tw_addr0: got %h want 010", wr_addr[b%64]); else passed++;
    checks++; if (wr_addr[(b+1)%64] !== 12'h011) $display("FAIL tw_addr1: got %h want 011", wr_addr[(b+1)%64]); else passed++;
    checks++; if (wr_lo[b%64] !== 32'd0) $display("FAIL tw_lo0: got %h want 0", wr_lo[b%64]); else passed++;
    checks++; if (wr_lo[(b+1)%64] !== 32'd10) $display("FAIL tw_lo1: got %h want a", wr_lo[(b+1)%64]); else passed++;
    checks++; if (wr_hi[b%64] !== 19'd9) $display("FAIL tw_hi0: got %h want 9", wr_hi[b%64]); else passed++;
    checks++; if (wr_hi[(b+1)%64] !== 19'd19) $display("FAIL tw_hi1: got %h want 13", wr_hi[(b+1)%64]); else passed++;
    checks++; if (wr_en[b%64] !== 1'b1) $display("FAIL tw_en: got %b want 1", wr_en[b%64]); else passed++;
    checks++; if (wr_cyc[(b+1)%64] - wr_cyc[b%64] != 11) $display("FAIL tw_spacing: got %0d want 11", wr_cyc[(b+1)%64] - wr_cyc[b%64]); else passed++;
    checks++; if (load_done !== 1'b1) $display("FAIL tw_done: got %b want 1", load_done); else passed++;
    checks++; if (words_written !== 13'd2) $display("FAIL tw_words: got %0d want 2", words_written); else passed++;
    checks++; if (load_err !== 1'b0) $display("FAIL tw_err: got %b want 0", load_err); else passed++;
  endtask

  task automatic test_wrap();
    int b = wr_n;
    start(12'hFFF, 13'd2);
    stream(0, 20, 1);
    wait_idle();
    checks++; if (wr_n - b != 2) $display("FAIL wrap_writes: got %0d want 2", wr_n - b); else passed++;
    checks++; if (wr_addr[b%64] !== 12'hFFF) $display("FAIL wrap_addr0: got %h want fff", wr_addr[b%64]); else passed++;
    checks++; if (wr_addr[(b+1)%64] !== 12'h000) $display("FAIL wrap_addr1: got %h want 000", wr_addr[(b+1)%64]); else passed++;
    checks++; if (words_written !== 13'd2) $display("FAIL wrap_words: got %0d want 2", words_written); else passed++;
  endtask

  task automatic test_gapped();
    int b = wr_n;
    for (int i = 0; i < 10; i++) beat_data[i] = 32'h5A00_0000 + 32'(i);
    start(12'h200, 13'd1);
    stream(0, 10, 3);
    wait_idle();
    checks++; if (wr_n - b != 1) $display("FAIL gap_writes: got %0d want 1", wr_n - b); else passed++;
    checks++; if (wr_rdy[b%64] !== 1'b0) $display("FAIL gap_ready_in_write: got %b want 0", wr_rdy[b%64]); else passed++;
    checks++; if (wr_lo[b%64] !== 32'h5A00_0000) $display("FAIL gap_lo: got %h want 5a000000", wr_lo[b%64]); else passed++;
    checks++; if (wr_hi[b%64] !== 19'd9) $display("FAIL gap_hi: got %h want 9", wr_hi[b%64]); else passed++;
    checks++; if (load_done !== 1'b1) $display("FAIL gap_done: got %b want 1", load_done); else passed++;
  endtask

  task automatic test_abort();
    int b = wr_n;
    for (int i = 0; i < 10; i++) beat_data[i] = 32'hDEAD_0000 + 32'(i);
    start(12'h020, 13'd1);
    stream(0, 6, 1);
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    checks++; if (load_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", load_busy); else passed++;
    checks++; if (load_done !== 1'b0) $display("FAIL abort_done: got %b want 0", load_done); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (wr_n - b != 0) $display("FAIL abort_writes: got %0d want 0", wr_n - b); else passed++;
    // Start and abort together: abort wins.
    load_start = 1'b1; load_abort = 1'b1; load_count = 13'd1;
    @(negedge clk);
    load_start = 1'b0; load_abort = 1'b0;
    checks++; if (load_busy !== 1'b0) $display("FAIL abort_start_busy: got %b want 0", load_busy); else passed++;
    // A fresh word must not inherit any partial beats.
    for (int i = 0; i < 10; i++) beat_data[i] = 32'd100 + 32'(i);
    start(12'h030, 13'd1);
    stream(0, 10, 1);
    wait_idle();
    checks++; if (wr_n - b != 1) $display("FAIL abort_next_writes: got %0d want 1", wr_n - b); else passed++;
    checks++; if (wr_lo[b%64] !== 32'd100) $display("FAIL abort_next_lo: got %0d want 100", wr_lo[b%64]); else passed++;
    checks++; if (wr_hi[b%64] !== 19'd109) $display("FAIL abort_next_hi: got %0d want 109", wr_hi[b%64]); else passed++;
  endtask

  task automatic test_busy_start();
    int b = wr_n;
    for (int i = 0; i < 20; i++) beat_data[i] = 32'(i);
    start(12'h040, 13'd2);
    stream(0, 4, 1);
    load_base = 12'h100; load_count = 13'd5; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++; if (bif.S_READY !== 1'b1) $display("FAIL busy_still_collect: got %b want 1", bif.S_READY); else passed++;
    stream(4, 16, 1);
    wait_idle();
    checks++; if (load_err !== 1'b1) $display("FAIL busy_err: got %b want 1", load_err); else passed++;
    checks++; if (wr_n - b != 2) $display("FAIL busy_writes: got %0d want 2", wr_n - b); else passed++;
    checks++; if (wr_addr[(b+1)%64] !== 12'h041) $display("FAIL busy_addr1: got %h want 041", wr_addr[(b+1)%64]); else passed++;
    checks++; if (wr_lo[(b+1)%64] !== 32'd10) $display("FAIL busy_lo1: got %0d want 10", wr_lo[(b+1)%64]); else passed++;
    checks++; if (words_written !== 13'd2) $display("FAIL busy_words: got %0d want 2", words_written); else passed++;
    checks++; if (load_done !== 1'b1) $display("FAIL busy_done: got %b want 1", load_done); else passed++;
  endtask

  task automatic test_pad();
    int b = wr_n;
    for (int i = 0; i < 9; i++) beat_data[i] = 32'(i);
    beat_data[9] = 32'h0007_FFFF;
    start(12'h300, 13'd1);
    checks++; if (load_err !== 1'b0) $display("FAIL pad_err_cleared: got %b want 0", load_err); else passed++;
    stream(0, 10, 1);
    wait_idle();
    checks++; if (load_err !== 1'b0) $display("FAIL pad_clean_err: got %b want 0", load_err); else passed++;
    checks++; if (wr_hi[b%64] !== 19'h7FFFF) $display("FAIL pad_clean_hi: got %h want 7ffff", wr_hi[b%64]); else passed++;
    beat_data[9] = 32'hFFF8_0000;
    start(12'h301, 13'd1);
    stream(0, 10, 1);
    wait_idle();
    checks++; if (wr_n - b != 2) $display("FAIL pad_writes: got %0d want 2", wr_n - b); else passed++;
    checks++; if (wr_hi[(b+1)%64] !== 19'h0) $display("FAIL pad_hi: got %h want 0", wr_hi[(b+1)%64]); else passed++;
    checks++; if (load_err !== PadExp) $display("FAIL pad_err: got %b want %b", load_err, PadExp); else passed++;
  endtask

  task automatic test_reset_mid();
    int b = wr_n;
    for (int i = 0; i < 10; i++) beat_data[i] = 32'h1111_0001 + 32'(i);
    start(12'h050, 13'd1);
    stream(0, 5, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (load_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", load_busy); else passed++;
    checks++; if (bif.S_READY !== 1'b0) $display("FAIL rmid_ready: got %b want 0", bif.S_READY); else passed++;
    checks++; if (inst_din !== '0) $display("FAIL rmid_din: got %h want 0", inst_din[31:0]); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (wr_n - b != 0) $display("FAIL rmid_writes: got %0d want 0", wr_n - b); else passed++;
    checks++; if (load_busy !== 1'b0) $display("FAIL rmid_idle: got %b want 0", load_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_two_words();
    test_wrap();
    test_gapped();
    test_abort();
    test_busy_start();
    test_pad();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
